icache_dm: RTL and testbench

//  Direct-mapped, read-only instruction cache between IF and instruction memory.
//  IF drives the fetch address; a hit returns the instruction combinationally in the same cycle.
//  On a miss the cache raises stall_out and refills one whole line from memory, one word per beat.

---
 rtl/icache_dm.sv | 113 +++++++++++
 tb/tb_icache_dm.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: a hit returns the instruction in the same cycle, and a
// miss stalls IF while one whole line is refilled from memory, one word per beat.
module icache_dm #(
  parameter int unsigned NUM_LINES      = 64,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  input  logic [31:0] addr_in,
  input  logic        flush,
  output logic [31:0] instr_out,
  output logic        stall_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] miss_count
);

  localparam int unsigned WB = $clog2(WORDS_PER_LINE);
  localparam int unsigned IB = $clog2(NUM_LINES);
  localparam int unsigned TB = 32 - 2 - WB - IB;

  typedef enum logic [1:0] {StIdle, StReq, StFill} state_e;

  state_e                state_q;
  logic [NUM_LINES-1:0]  valid_q;
  logic                  flush_pend_q;
  logic [WB-1:0]         beat_q;

  logic [TB-1:0]         tag_mem  [NUM_LINES];
  logic [31:0]           data_mem [NUM_LINES*WORDS_PER_LINE];

  logic [WB-1:0]         word;
  logic [IB-1:0]         index;
  logic [TB-1:0]         tag;
  logic [IB-1:0]         fill_idx;
  logic [TB-1:0]         fill_tag;
  logic                  hit;
  logic                  last_beat;
  logic [1:0]            unused_addr;

  assign word        = addr_in[2+WB-1:2];
  assign index       = addr_in[2+WB+IB-1:2+WB];
  assign tag         = addr_in[31:32-TB];
  assign unused_addr = addr_in[1:0];

  // The line being refilled is always taken from the latched address, never from addr_in.
  assign fill_idx  = mem_addr[2+WB+IB-1:2+WB];
  assign fill_tag  = mem_addr[31:32-TB];
  assign last_beat = mem_rvalid && (beat_q == WB'(WORDS_PER_LINE - 1));

  assign hit       = (state_q == StIdle) && valid_q[index] && (tag_mem[index] == tag) && !flush;
  assign instr_out = hit ? data_mem[{index, word}] : 32'h0;
  assign stall_out = req_valid && !hit;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= 32'h0;
      beat_q       <= '0;
      miss_count   <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (flush) begin
            valid_q <= '0;
          end else if (req_valid && !hit) begin
            mem_addr <= {addr_in[31:2+WB], {(2+WB){1'b0}}};
            if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            mem_req  <= 1'b1;
            state_q  <= StReq;
          end
        end
        StReq: begin
          if (flush) flush_pend_q <= 1'b1;
          if (mem_gnt) begin
            mem_req <= 1'b0;
            beat_q  <= '0;
            state_q <= StFill;
          end
        end
        StFill: begin
          if (flush) flush_pend_q <= 1'b1;
          if (mem_rvalid) begin
            beat_q <= beat_q + WB'(1);
            if (last_beat) begin
              state_q      <= StIdle;
              flush_pend_q <= 1'b0;
              // A flush seen during the refill also drops the line just written.
              if (flush_pend_q || flush) valid_q <= '0;
              else valid_q[fill_idx] <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (state_q == StFill && mem_rvalid) begin
      data_mem[{fill_idx, beat_q}] <= mem_rdata;
      if (last_beat) tag_mem[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: a scoreboard queue holds expected instructions, and immediate
// assertions compare hits, stalls, refill handshakes, flush and reset behaviour.
module tb_icache_dm;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req_valid;
  logic [31:0] addr_in;
  logic        flush;
  logic [31:0] instr_out;
  logic        stall_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] miss_count;

  int          passed = 0;
  int          total  = 0;
  int          cyc    = 0;
  int          miss_cyc;
  logic [31:0] exp_q [$];

  icache_dm #(.NUM_LINES(64), .WORDS_PER_LINE(4)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .req_valid  (req_valid),
    .addr_in    (addr_in),
    .flush      (flush),
    .instr_out  (instr_out),
    .stall_out  (stall_out),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .miss_count (miss_count)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", name, obs, exp);
  endfunction

  task automatic step();
    @(negedge CLK);
  endtask

  // Starts at a negedge in IDLE; leaves the bench just after the first REQ-cycle negedge.
  task automatic miss(input logic [31:0] a, input logic [31:0] cnt);
    req_valid = 1'b1;
    addr_in   = a;
    miss_cyc  = cyc;
    #2;
    chk("miss_stall", stall_out, 32'd1);
    chk("miss_instr_zero", instr_out, 32'h0);
    step();
    #2;
    chk("miss_mem_req", mem_req, 32'd1);
    chk("miss_mem_addr", mem_addr, {a[31:4], 4'h0});
    chk("miss_count", miss_count, cnt);
  endtask

  // Serves one refill; returns at the negedge following the last beat.
  task automatic refill(input logic [31:0] base, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3, input int gnt_wait,
                        input int gap, input int flush_beat);
    logic [31:0] d [4];
    int n;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      step();
      #2;
      n++;
    end
    chk("refill_req_up", mem_req, 32'd1);
    if (mem_req !== 1'b1) return;
    repeat (gnt_wait) begin
      step();
      #2;
      chk("req_held", mem_req, 32'd1);
      chk("addr_held", mem_addr, base);
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (gap) begin
        mem_rvalid = 1'b0;
        step();
      end
      mem_rvalid = 1'b1;
      mem_rdata  = d[i];
      flush      = (i == flush_beat);
      #2;
      if (i == 0) chk("req_dropped", mem_req, 32'd0);
      chk("fill_stall", stall_out, 32'd1);
      step();
      flush = 1'b0;
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp);
    req_valid = 1'b1;
    addr_in   = a;
    exp_q.push_back(exp);
    #2;
    chk("hit_stall", stall_out, 32'd0);
    chk("hit_no_req", mem_req, 32'd0);
    chk("hit_instr", instr_out, exp_q.pop_front());
    step();
  endtask

  initial begin
    RESET = 1'b0; req_valid = 1'b1; addr_in = 32'hBFC0_0000; flush = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    step();
    step();
    chk("rst_mem_req", mem_req, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_miss_count", miss_count, 32'd0);
    chk("rst_stall", stall_out, 32'd1);
    chk("rst_instr", instr_out, 32'h0);
    RESET = 1'b1;
    step();

    // Cold miss, zero-wait refill, then hits on the remaining words.
    miss(32'hBFC0_0000, 32'd1);
    refill(32'hBFC0_0000, 32'h11, 32'h22, 32'h33, 32'h44, 0, 0, -1);
    chk("refill_latency", cyc - miss_cyc, 32'd6);
    fetch(32'hBFC0_0000, 32'h11);
    fetch(32'hBFC0_0004, 32'h22);
    fetch(32'hBFC0_0008, 32'h33);
    fetch(32'hBFC0_000C, 32'h44);

    // Conflict on index 0 with a new tag evicts the line.
    miss(32'hBFC0_0400, 32'd2);
    refill(32'hBFC0_0400, 32'h55, 32'h66, 32'h77, 32'h88, 0, 0, -1);
    fetch(32'hBFC0_0400, 32'h55);
    fetch(32'hBFC0_040C, 32'h88);
    miss(32'hBFC0_0000, 32'd3);
    refill(32'hBFC0_0000, 32'h11, 32'h22, 32'h33, 32'h44, 0, 0, -1);
    fetch(32'hBFC0_0008, 32'h33);

    // Delayed grant and gaps between beats.
    miss(32'h0000_1234, 32'd4);
    refill(32'h0000_1230, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 3, 2, -1);
    fetch(32'h0000_1230, 32'hA1);
    fetch(32'h0000_1234, 32'hA2);
    fetch(32'h0000_1238, 32'hA3);
    fetch(32'h0000_123C, 32'hA4);
    fetch(32'hBFC0_0004, 32'h22);

    // Flush in IDLE: no miss started that cycle, next lookup misses.
    req_valid = 1'b1; addr_in = 32'hBFC0_0000; flush = 1'b1;
    #2;
    chk("flush_stall", stall_out, 32'd1);
    chk("flush_instr", instr_out, 32'h0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_no_req", mem_req, 32'd0);
    chk("flush_no_count", miss_count, 32'd4);
    miss(32'hBFC0_0000, 32'd5);
    refill(32'hBFC0_0000, 32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 1);
    // Flush mid-fill: the just-filled line is not valid.
    miss(32'hBFC0_0000, 32'd6);
    refill(32'hBFC0_0000, 32'h11, 32'h22, 32'h33, 32'h44, 1, 0, -1);
    fetch(32'hBFC0_0000, 32'h11);

    // Reset after two beats of a refill.
    miss(32'h0000_1230, 32'd7);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hC1;
    step();
    mem_rdata = 32'hC2;
    step();
    mem_rvalid = 1'b0;
    RESET = 1'b0;
    #1;
    chk("midrst_mem_req", mem_req, 32'd0);
    chk("midrst_count", miss_count, 32'd0);
    chk("midrst_stall", stall_out, 32'd1);
    step();
    RESET = 1'b1; req_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_rvalid = 1'b0;
    #1;
    chk("stray_no_req", mem_req, 32'd0);
    chk("stray_count", miss_count, 32'd0);
    miss(32'h0000_1230, 32'd1);
    refill(32'h0000_1230, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 1, 1, -1);
    fetch(32'h0000_1230, 32'hB1);
    fetch(32'h0000_123C, 32'hB4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
